// File: rtl/vga_in_monitor.sv
// vga_in_monitor: samples an incoming VGA stream, measures line/frame timing, locks and recovers pixel X/Y.
// Optional VGA_IN_CRC_EN adds FRAME_CRC, a CRC-16-CCITT over the valid pixels of each frame.
module vga_in_monitor #(
  parameter int H_SYNC = 96,
  parameter int H_BACK = 48,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT = 16,
  parameter int V_SYNC = 2,
  parameter int V_BACK = 33,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT = 10,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       PIX_EN,
  input  logic       VGA_HS,
  input  logic       VGA_VS,
  input  logic [3:0] VGA_R,
  input  logic [3:0] VGA_G,
  input  logic [3:0] VGA_B,
  output logic       PIX_VALID,
  output logic [9:0] PIX_X,
  output logic [9:0] PIX_Y,
  output logic [3:0] PIX_R,
  output logic [3:0] PIX_G,
  output logic [3:0] PIX_B,
  output logic       LOCKED,
  output logic [9:0] LINE_LEN,
  output logic [9:0] FRAME_LINES,
  output logic [7:0] ERR_CNT
`ifdef VGA_IN_CRC_EN
  , output logic [15:0] FRAME_CRC
`endif
);
  localparam logic [1:0] SEARCH = 2'd0, ACQUIRE = 2'd1, LOCK = 2'd2;
  localparam logic [9:0] H_TOT = 10'(H_SYNC + H_BACK + H_DISPLAY + H_FRONT);
  localparam logic [9:0] V_TOT = 10'(V_SYNC + V_BACK + V_DISPLAY + V_FRONT);
  localparam logic [9:0] H_SW = 10'(H_SYNC), V_SW = 10'(V_SYNC);
  localparam logic [9:0] H_OFF = 10'(H_SYNC + H_BACK), H_END = 10'(H_SYNC + H_BACK + H_DISPLAY);
  localparam logic [9:0] V_OFF = 10'(V_SYNC + V_BACK), V_END = 10'(V_SYNC + V_BACK + V_DISPLAY);
  localparam logic [9:0] SAT = 10'h3ff;
  logic hs1, vs1, hs2, vs2, hs3, vs3, armed, frame_bad;
  logic [11:0] rgb1, rgb2;
  logic [9:0] h_cnt, v_cnt, vs_w, h_nxt, v_nxt, vs_w_nxt;
  logic [1:0] state, state_nxt;
  logic [7:0] good_cnt, good_nxt;
  logic hs_fall, hs_rise, vs_fall, vs_rise, timeout, line_err, vs_err, frame_err, err_inc, win, valid_nxt;
  // Counters hold the index of the pixel now in stage 2, so outputs use the next-count values.
  always_comb begin
    hs_fall = hs3 & ~hs2;
    hs_rise = ~hs3 & hs2;
    vs_fall = vs3 & ~vs2;
    vs_rise = ~vs3 & vs2;
    h_nxt = hs_fall ? '0 : h_cnt + 10'(h_cnt != SAT);
    v_nxt = !hs_fall ? v_cnt : (armed || vs_fall) ? '0 : v_cnt + 10'(v_cnt != SAT);
    vs_w_nxt = vs_fall ? 10'(hs_fall) : vs_w + 10'(hs_fall && !vs2 && vs_w != SAT);
    timeout = !hs_fall && h_cnt == SAT - 10'd1;
    line_err = (hs_fall && h_cnt + 10'd1 != H_TOT) || (hs_rise && h_cnt + 10'd1 != H_SW);
    vs_err = vs_rise && vs_w != V_SW;
    frame_err = frame_bad || line_err || timeout || v_cnt + 10'd1 != V_TOT;
    win = h_nxt >= H_OFF && h_nxt < H_END && v_nxt >= V_OFF && v_nxt < V_END;
    state_nxt = state;
    good_nxt = good_cnt;
    err_inc = 1'b0;
    if (state == SEARCH) begin
      if (vs_fall) begin
        state_nxt = ACQUIRE;
        good_nxt = '0;
      end
    end else if (state == ACQUIRE) begin
      if (vs_fall) begin
        good_nxt = frame_err ? '0 : good_cnt + 8'd1;
        if (!frame_err && good_cnt + 8'd1 >= 8'(LOCK_FRAMES)) state_nxt = LOCK;
      end else if (timeout) good_nxt = '0;
    end else if (line_err || timeout || (vs_fall && frame_err)) begin
      state_nxt = SEARCH;
      err_inc = 1'b1;
    end
    valid_nxt = win && state_nxt == LOCK;
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      {hs1, vs1, hs2, vs2, hs3, vs3} <= '1;
      {rgb1, rgb2} <= '0;
      {h_cnt, v_cnt, vs_w, armed, frame_bad, good_cnt} <= '0;
      state <= SEARCH;
      {PIX_VALID, PIX_X, PIX_Y, PIX_R, PIX_G, PIX_B, LOCKED} <= '0;
      {LINE_LEN, FRAME_LINES, ERR_CNT} <= '0;
    end else if (PIX_EN) begin
      {hs1, vs1, rgb1} <= {VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B};
      {hs2, vs2, rgb2} <= {hs1, vs1, rgb1};
      {hs3, vs3} <= {hs2, vs2};
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
      vs_w <= vs_w_nxt;
      armed <= vs_fall ? !hs_fall : armed && !hs_fall;
      frame_bad <= vs_fall ? 1'b0 : frame_bad || line_err || timeout || vs_err;
      state <= state_nxt;
      good_cnt <= good_nxt;
      PIX_VALID <= valid_nxt;
      PIX_X <= h_nxt - H_OFF;
      PIX_Y <= v_nxt - V_OFF;
      {PIX_R, PIX_G, PIX_B} <= win ? rgb2 : '0;
      LOCKED <= state_nxt == LOCK;
      LINE_LEN <= hs_fall ? h_cnt + 10'd1 : LINE_LEN;
      FRAME_LINES <= vs_fall ? v_cnt + 10'd1 : FRAME_LINES;
      ERR_CNT <= ERR_CNT + 8'(err_inc && ERR_CNT != 8'hff);
    end
  end
`ifdef VGA_IN_CRC_EN
  logic [15:0] crc;
  function automatic logic [15:0] crc12(input logic [15:0] c, input logic [11:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 11; i >= 0; i--) r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0);
    return r;
  endfunction
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      crc <= 16'hffff;
      FRAME_CRC <= '0;
    end else if (PIX_EN) begin
      FRAME_CRC <= vs_fall ? crc : FRAME_CRC;
      crc <= vs_fall ? 16'hffff : valid_nxt ? crc12(crc, rgb2) : crc;
    end
  end
`endif
endmodule

// File: doc/vga_in_monitor.md
Name: vga_in_monitor

Overview:
- Receive-side counterpart of the VGA output block: samples an incoming VGA stream (HS, VS, 4-bit RGB) and recovers the pixel grid.
- Measures line and frame timing, checks it against the configured 640x480 mode and declares lock.
- Once locked, outputs display pixels with recovered X/Y coordinates.
- Used for loopback checking of our VGA output and as the front end of capture logic.

Parameters:
- H_SYNC, 96: expected HS low width, pixels
- H_BACK, 48: pixels from HS rise to first display pixel
- H_DISPLAY, 640: display pixels per line
- H_FRONT, 16: pixels from display end to HS fall
- V_SYNC, 2: expected VS low width, lines
- V_BACK, 33: lines from VS rise to first display line
- V_DISPLAY, 480: display lines per frame
- V_FRONT, 10: lines after display before VS fall
- LOCK_FRAMES, 2: consecutive good frames required for lock

Ports:
- CLK  in  1  system clock, 50 MHz
- RST_N  in  1  asynchronous active-low reset
- PIX_EN  in  1  pixel strobe; one CLK cycle high per pixel (25 MHz)
- VGA_HS  in  1  horizontal sync, active low
- VGA_VS  in  1  vertical sync, active low
- VGA_R, VGA_G, VGA_B  in  4 each  incoming colour
- PIX_VALID  out  1  display pixel present this strobe
- PIX_X  out  10  recovered column 0..H_DISPLAY-1
- PIX_Y  out  10  recovered row 0..V_DISPLAY-1
- PIX_R, PIX_G, PIX_B  out  4 each  recovered colour
- LOCKED  out  1  timing locked
- LINE_LEN  out  10  last measured line length, pixels
- FRAME_LINES  out  10  last measured lines per frame
- ERR_CNT  out  8  lock-loss count, saturating at 255

Behaviour:
- All state advances only on CLK edges with PIX_EN=1. CLK edges with PIX_EN=0 hold all state.
- Reset (async, RST_N=0):
  - All outputs are 0.
  - State is SEARCH.
  - Synchroniser and pipeline stages are cleared to HS=1, VS=1, RGB=0.
- Input pipeline:
  - HS, VS and RGB pass through 2 PIX_EN-qualified register stages together, which keeps them aligned.
  - Edges are detected on stage 2.
  - Outputs are registered once more: an input sampled on strobe n appears on outputs after strobe n+2 (3-strobe latency).
- h_cnt (10 b):
  - Set to 0 on the strobe where an HS fall is detected; increments otherwise.
  - Saturates at 1023. Reaching 1023 is a timeout.
  - On HS fall: LINE_LEN <= h_cnt+1 (the count since the previous fall).
  - On HS rise: the HS width is h_cnt+1.
- VS fall arms a new frame. The first HS fall after arming sets v_cnt to 0; each later HS fall increments v_cnt, saturating at 1023.
  - Before the next arming, FRAME_LINES <= v_cnt+1.
  - VS width = number of HS falls between VS fall and VS rise.
- Frame is good when all of the following hold:
  - every LINE_LEN = H_SYNC+H_BACK+H_DISPLAY+H_FRONT (800);
  - every HS width = H_SYNC;
  - FRAME_LINES = 525;
  - VS width = V_SYNC;
  - no timeout.
- FSM:
  - SEARCH: wait for VS fall, then go to ACQUIRE with good_cnt=0.
  - ACQUIRE: at each VS fall, if the frame was good then good_cnt++, else good_cnt=0. When good_cnt reaches LOCK_FRAMES, go to LOCKED.
  - LOCKED: LOCKED=1. Any bad line, bad HS width, timeout, or bad frame at VS fall causes ERR_CNT++ (saturating), LOCKED=0 and a return to SEARCH on the next strobe.
- Display window:
  - h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_DISPLAY) and v_cnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_DISPLAY).
  - PIX_VALID=1 only inside the window and only while LOCKED.
  - PIX_X = h_cnt-144, PIX_Y = v_cnt-35 (10-bit, wrap unused).
  - PIX_R/G/B always carry delayed RGB; outside the window they are forced to 0.
- Simultaneous events:
  - HS fall and VS fall on the same strobe: the HS fall is treated as line 0 of the new frame.
  - Timeout during SEARCH or ACQUIRE: good_cnt=0, ERR_CNT unchanged.
- Reset mid-frame: immediate return to the reset state; no partial measurements survive.

Optional Feature:
- Macro: VGA_IN_CRC_EN.
- Defined:
  - Adds output FRAME_CRC (16 b), CRC-16-CCITT (poly 0x1021, init 0xFFFF).
  - Runs over {R,G,B} (12 bits, MSB first) of every PIX_VALID pixel.
  - At each VS fall the running value is copied to FRAME_CRC and the running value reinitialises to 0xFFFF.
  - FRAME_CRC resets to 0.
- Undefined: no port and no CRC logic.

Test Plan:
- Ideal 640x480 stream (800x525, H 16/96/48, V 10/2/33), PIX_EN every 2nd CLK:
  - LOCKED rises at the VS fall ending the 2nd complete frame after the first VS fall.
  - LINE_LEN=800, FRAME_LINES=525.
  - 307200 PIX_VALID per frame, with first pixel X=0/Y=0 and last pixel X=639/Y=479.
- Pattern RGB=X[3:0] replicated on all channels: every PIX_VALID has PIX_R=PIX_X[3:0], confirming 3-strobe alignment.
- After lock, one line shortened to 799: LOCKED falls within 4 strobes and ERR_CNT=1. Relock occurs after 2 good frames.
- HS held high for 1100 strobes while locked: timeout, LOCKED=0, ERR_CNT increments. Unlocked, the same stimulus leaves ERR_CNT unchanged.
- VS width 3 lines in every frame: never locks, PIX_VALID stays 0.
- RST_N pulsed low mid-frame while locked: all outputs 0 immediately, state SEARCH, relock after 2 frames. With VGA_IN_CRC_EN, the all-white frame CRC matches the software model and two identical frames give an identical FRAME_CRC.
